// File: rtl/aes_gcm_blk_packer_if.sv
// Byte-stream input and 128-bit block output handshakes of the GCM block packer.
// master: upstream source and downstream block sink; slave: the packer itself.
interface aes_gcm_blk_packer_if #(
   parameter int unsigned IN_BYTES = 4
);
   logic                    in_valid;
   logic                    in_ready;
   logic [8*IN_BYTES-1:0]   in_data;
   logic [IN_BYTES-1:0]     in_keep;
   logic                    in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic [127:0]            out_data;
   logic [15:0]             out_keep;
   logic                    out_last;

   modport master (
      output in_valid, in_data, in_keep, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_keep, out_last
   );

   modport slave (
      input  in_valid, in_data, in_keep, in_last, out_ready,
      output in_ready, out_valid, out_data, out_keep, out_last
   );
endinterface

// File: rtl/aes_gcm_blk_packer.sv
// Packs a narrow AAD/payload byte stream into zero-padded 128-bit GHASH/CTR blocks
// with an MSB-contiguous keep mask, a last flag and a running bit-length count.
module aes_gcm_blk_packer #(
   parameter int unsigned IN_BYTES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   aes_gcm_blk_packer_if.slave  bus,
   output logic [63:0]          msg_bits,
   output logic                 msg_done,
   output logic                 proto_err
);
   localparam int unsigned WORD_W = 8 * IN_BYTES;
   localparam int unsigned CNT_W  = $clog2(IN_BYTES + 1);
   localparam int unsigned PAD_W  = 128 - WORD_W;

   typedef enum logic {
      FILL,
      HOLD
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [127:0]        acc;
   logic [127:0]        acc_nxt;
   logic [4:0]          fill;
   logic [4:0]          fill_nxt;
   logic [127:0]        data_q;
   logic [127:0]        data_nxt;
   logic [15:0]         keep_q;
   logic [15:0]         keep_nxt;
   logic                last_q;
   logic                last_nxt;
   logic                valid_q;
   logic                valid_nxt;
   logic [63:0]         bits_nxt;
   logic                done_nxt;
   logic                err_nxt;
   logic                pend;
   logic                pend_nxt;

   logic [CNT_W-1:0]    cnt;
   logic [IN_BYTES-1:0] keep_exp;
   logic                keep_legal;
   logic [WORD_W-1:0]   word_masked;
   logic [127:0]        word_hi;
   logic [127:0]        merged;
   logic [5:0]          fill_sum;
   logic [15:0]         blk_keep;
   logic                complete;
   logic                in_fire;
   logic                out_fire;

   assign bus.in_ready  = !valid_q || bus.out_ready;
   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign bus.out_keep  = keep_q;
   assign bus.out_last  = last_q;

   assign in_fire  = bus.in_valid && bus.in_ready;
   assign out_fire = valid_q && bus.out_ready;

   // Byte count of the incoming word and the MSB-first lanes it covers.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < int'(IN_BYTES); i++) begin
         cnt = cnt + CNT_W'(bus.in_keep[i]);
      end
   end

   assign keep_exp   = ~({IN_BYTES{1'b1}} >> cnt);
   assign keep_legal = (bus.in_keep == keep_exp) &&
                       (bus.in_last || (cnt == CNT_W'(IN_BYTES)));

   // Take the first cnt bytes of the word; lanes beyond them are forced to zero.
   always_comb begin
      word_masked = '0;
      for (int i = 0; i < int'(IN_BYTES); i++) begin
         if (CNT_W'(i) < cnt) begin
            word_masked[8*(int'(IN_BYTES)-1-i) +: 8] = bus.in_data[8*(int'(IN_BYTES)-1-i) +: 8];
         end
      end
   end

   assign word_hi  = 128'(word_masked) << PAD_W;
   assign merged   = acc | (word_hi >> {fill, 3'b000});
   assign fill_sum = 6'(fill) + 6'(cnt);
   assign blk_keep = ~(16'hFFFF >> fill_sum);
   assign complete = (fill_sum >= 6'd16) || bus.in_last;

   // Next-state, accumulator and output-register update.
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      fill_nxt  = fill;
      data_nxt  = data_q;
      keep_nxt  = keep_q;
      last_nxt  = last_q;
      bits_nxt  = msg_bits;
      pend_nxt  = pend;
      err_nxt   = proto_err;
      done_nxt  = out_fire && last_q;

      case (state)
         FILL: begin
            if (in_fire && complete) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (out_fire) begin
               state_nxt = (in_fire && complete) ? HOLD : FILL;
            end
         end
         default: state_nxt = FILL;
      endcase

      if (in_fire) begin
         if (!keep_legal) begin
            err_nxt = 1'b1;
         end
         // A pending end-of-message restarts the length count on the next word.
         bits_nxt = (pend ? 64'd0 : msg_bits) + (64'(cnt) << 3);
         pend_nxt = bus.in_last;
         if (complete) begin
            data_nxt = merged;
            keep_nxt = blk_keep;
            last_nxt = bus.in_last;
            acc_nxt  = '0;
            fill_nxt = '0;
         end else begin
            acc_nxt  = merged;
            fill_nxt = fill_sum[4:0];
         end
      end

      valid_nxt = (state_nxt == HOLD);
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state     <= FILL;
         acc       <= '0;
         fill      <= '0;
         data_q    <= '0;
         keep_q    <= '0;
         last_q    <= 1'b0;
         valid_q   <= 1'b0;
         msg_bits  <= '0;
         msg_done  <= 1'b0;
         proto_err <= 1'b0;
         pend      <= 1'b0;
      end else begin
         state     <= state_nxt;
         acc       <= acc_nxt;
         fill      <= fill_nxt;
         data_q    <= data_nxt;
         keep_q    <= keep_nxt;
         last_q    <= last_nxt;
         valid_q   <= valid_nxt;
         msg_bits  <= bits_nxt;
         msg_done  <= done_nxt;
         proto_err <= err_nxt;
         pend      <= pend_nxt;
      end
   end
endmodule

// File: tb/tb_aes_gcm_blk_packer.sv
// Directed bench for aes_gcm_blk_packer (IN_BYTES=4) with a byte-queue reference model
// checked every cycle plus literal expectations per scenario.
module tb_aes_gcm_blk_packer;
   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [63:0] msg_bits;
   logic        msg_done;
   logic        proto_err;

   int errors = 0;
   int checks = 0;

   aes_gcm_blk_packer_if #(.IN_BYTES(4)) bus ();

   aes_gcm_blk_packer #(.IN_BYTES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .bus       (bus),
      .msg_bits  (msg_bits),
      .msg_done  (msg_done),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] data;
      logic [15:0]  keep;
      logic         last;
   } blk_t;

   blk_t        exp_q[$];
   logic [7:0]  cur[$];
   logic [63:0] m_bits;
   bit          m_pend;
   bit          m_err;
   bit          m_done;
   bit          armed = 0;

   logic [127:0] cap_data;
   logic [15:0]  cap_keep;
   logic         cap_last;
   int           done_cnt = 0;

   function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Reference model and per-cycle compare, sampled on the falling edge.
   always @(negedge clk) begin
      bit          mv;
      bit          done_n;
      int          n;
      bit          legal;
      blk_t        b;
      logic [3:0]  k;
      logic [31:0] d;
      if (armed) begin
         mv = (exp_q.size() > 0);
         chk("out_valid", 128'(bus.out_valid), 128'(mv));
         if (mv) begin
            chk("out_data", bus.out_data, exp_q[0].data);
            chk("out_keep", 128'(bus.out_keep), 128'(exp_q[0].keep));
            chk("out_last", 128'(bus.out_last), 128'(exp_q[0].last));
         end
         chk("in_ready", 128'(bus.in_ready), 128'(!mv || bus.out_ready));
         chk("msg_bits", 128'(msg_bits), 128'(m_bits));
         chk("msg_done", 128'(msg_done), 128'(m_done));
         chk("proto_err", 128'(proto_err), 128'(m_err));
         if (bus.out_valid && bus.out_ready) begin
            cap_data = bus.out_data;
            cap_keep = bus.out_keep;
            cap_last = bus.out_last;
         end
         if (msg_done) done_cnt++;
      end
      if (rst || flush) begin
         exp_q.delete();
         cur.delete();
         m_bits = '0;
         m_pend = 0;
         m_err  = 0;
         m_done = 0;
         armed  = 1;
      end else if (armed) begin
         mv     = (exp_q.size() > 0);
         done_n = 0;
         if (mv && bus.out_ready) begin
            done_n = exp_q[0].last;
            void'(exp_q.pop_front());
         end
         if (bus.in_valid && (!mv || bus.out_ready)) begin
            k = bus.in_keep;
            d = bus.in_data;
            n = $countones(k);
            legal = (k == 4'hF) ||
                    (bus.in_last && (k == 4'h0 || k == 4'h8 || k == 4'hC || k == 4'hE));
            if (!legal) m_err = 1;
            if (m_pend) m_bits = '0;
            m_bits = m_bits + 64'(8 * n);
            m_pend = bus.in_last;
            for (int i = 0; i < n; i++) cur.push_back(d[31-8*i -: 8]);
            if (cur.size() >= 16 || bus.in_last) begin
               b.data = '0;
               b.keep = '0;
               for (int i = 0; i < cur.size() && i < 16; i++) begin
                  b.data[127-8*i -: 8] = cur[i];
                  b.keep[15-i] = 1'b1;
               end
               b.last = bus.in_last;
               exp_q.push_back(b);
               cur.delete();
            end
         end
         m_done = done_n;
      end
   end

   task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
      bit hs = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_keep  = k;
      bus.in_last  = l;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            hs = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (!hs) chk("send_timeout", 128'(0), 128'(1));
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!bus.out_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("drain_timeout", 128'(0), 128'(1));
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      rst           = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_keep   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // 1) one full message block
      d0 = done_cnt;
      send(32'h00010203, 4'hF, 1'b0);
      send(32'h04050607, 4'hF, 1'b0);
      send(32'h08090A0B, 4'hF, 1'b0);
      send(32'h0C0D0E0F, 4'hF, 1'b1);
      drain();
      chk("t1_data", cap_data, 128'h000102030405060708090A0B0C0D0E0F);
      chk("t1_keep", 128'(cap_keep), 128'hFFFF);
      chk("t1_last", 128'(cap_last), 128'h1);
      chk("t1_bits", 128'(msg_bits), 128'd128);
      chk("t1_done", 128'(done_cnt - d0), 128'd1);

      // 2) trailing partial word
      send(32'h00010203, 4'hF, 1'b0);
      send(32'h04050607, 4'hF, 1'b0);
      send(32'h08090A0B, 4'hF, 1'b0);
      send(32'h0C0D0E0F, 4'hF, 1'b0);
      send(32'hAABBCCDD, 4'hC, 1'b1);
      drain();
      chk("t2_data", cap_data, 128'hAABB0000000000000000000000000000);
      chk("t2_keep", 128'(cap_keep), 128'hC000);
      chk("t2_last", 128'(cap_last), 128'h1);
      chk("t2_bits", 128'(msg_bits), 128'd144);

      // 3) backpressure with a waiting input word
      bus.out_ready = 1'b0;
      send(32'h10111213, 4'hF, 1'b0);
      send(32'h14151617, 4'hF, 1'b0);
      send(32'h18191A1B, 4'hF, 1'b0);
      send(32'h1C1D1E1F, 4'hF, 1'b0);
      fork
         send(32'h20212223, 4'hF, 1'b0);
         begin
            repeat (10) @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      chk("t3_blk1", cap_data, 128'h101112131415161718191A1B1C1D1E1F);
      send(32'h24252627, 4'hF, 1'b0);
      send(32'h28292A2B, 4'hF, 1'b0);
      send(32'h2C2D2E2F, 4'hF, 1'b1);
      drain();
      chk("t3_blk2", cap_data, 128'h202122232425262728292A2B2C2D2E2F);
      chk("t3_bits", 128'(msg_bits), 128'd256);

      // 4) empty terminator after a full block
      send(32'h30313233, 4'hF, 1'b0);
      send(32'h34353637, 4'hF, 1'b0);
      send(32'h38393A3B, 4'hF, 1'b0);
      send(32'h3C3D3E3F, 4'hF, 1'b0);
      send(32'hDEADBEEF, 4'h0, 1'b1);
      drain();
      chk("t4_data", cap_data, 128'h0);
      chk("t4_keep", 128'(cap_keep), 128'h0);
      chk("t4_last", 128'(cap_last), 128'h1);
      chk("t4_bits", 128'(msg_bits), 128'd128);

      // 5) non-contiguous keep then flush
      send(32'h40414243, 4'hA, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("t5_err_set", 128'(proto_err), 128'h1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("t5_err_clr", 128'(proto_err), 128'h0);
      chk("t5_bits_clr", 128'(msg_bits), 128'h0);

      // 6) reset mid-message, then a clean message from offset 0
      send(32'h50515253, 4'hF, 1'b0);
      send(32'h54555657, 4'hF, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t6_rst_bits", 128'(msg_bits), 128'h0);
      send(32'h60616263, 4'hF, 1'b0);
      send(32'h64656667, 4'hF, 1'b0);
      send(32'h68696A6B, 4'hF, 1'b0);
      send(32'h6C6D6E6F, 4'hF, 1'b1);
      drain();
      chk("t6_data", cap_data, 128'h606162636465666768696A6B6C6D6E6F);
      chk("t6_bits", 128'(msg_bits), 128'd128);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
